address_bus_select: RTL and testbench

- Address-path steering block of the cpu6502 core.
- Combinationally selects the low address bus (ADL) and high address bus (ADH) sources from data input, PC select, stack pointer, ALU result, interrupt vector and fixed pages.
- Drives the PCHS-side ADH copy used by the PC high mux.
- Holds the registered external address bus (ABH:ABL), updated by microcode load strobes.

---
 rtl/addr_sel_pkg.sv | 23 ++
 rtl/address_bus_select_ab_reg8.sv | 16 +
 rtl/address_bus_select.sv | 81 ++++++++
 tb/tb_address_bus_select.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/addr_sel_pkg.sv
// Select encodings and page constants for the address-bus steering path.
// The microcode ROM generator uses the same constants, so keep the two in step.
package addr_sel_pkg;

  localparam logic [2:0] ADL_SEL_PCLS = 3'd0;
  localparam logic [2:0] ADL_SEL_DATA = 3'd1;
  localparam logic [2:0] ADL_SEL_S    = 3'd2;
  localparam logic [2:0] ADL_SEL_ALU  = 3'd3;
  localparam logic [2:0] ADL_SEL_VEC  = 3'd4;
  localparam logic [2:0] ADL_SEL_VEC1 = 3'd5;

  localparam logic [2:0] ADH_SEL_PCHS  = 3'd0;
  localparam logic [2:0] ADH_SEL_DATA  = 3'd1;
  localparam logic [2:0] ADH_SEL_ALU   = 3'd2;
  localparam logic [2:0] ADH_SEL_ZERO  = 3'd3;
  localparam logic [2:0] ADH_SEL_STACK = 3'd4;
  localparam logic [2:0] ADH_SEL_VEC   = 3'd5;

  localparam logic [7:0] STACK_PAGE_DEF  = 8'h01;
  localparam logic [7:0] VECTOR_PAGE_DEF = 8'hFF;
  localparam logic [7:0] RESET_VEC_LO    = 8'hFC;

endpackage

// File: rtl/address_bus_select_ab_reg8.sv
// 8-bit address-bus byte register: synchronous reset to a supplied value, load enable.
module ab_reg8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] rst_val,
  input  logic [7:0] d,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= rst_val;
    else if (en) q <= d;
  end

endmodule

// File: rtl/address_bus_select.sv
// ADL/ADH source muxes and the registered external address bus ABH:ABL.
// Define RESET_VECTOR_ADDR_EN to reset the address to the reset vector (FFFC).
module address_bus_select
  import addr_sel_pkg::*;
#(
  parameter logic [7:0] STACK_PAGE  = STACK_PAGE_DEF,
  parameter logic [7:0] VECTOR_PAGE = VECTOR_PAGE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  adl_sel,
  input  logic [2:0]  adh_sel,
  input  logic [7:0]  data_i,
  input  logic [7:0]  pcls,
  input  logic [7:0]  pchs,
  input  logic [7:0]  reg_s,
  input  logic [7:0]  alu,
  input  logic [7:0]  vector_lo,
  input  logic        load_abl,
  input  logic        load_abh,
  output logic [7:0]  adl_abl,
  output logic [7:0]  adh_abh,
  output logic [7:0]  adh_pchs,
  output logic [15:0] address
);

  always_comb begin
    adl_abl = 8'h00;
    case (adl_sel)
      ADL_SEL_PCLS: adl_abl = pcls;
      ADL_SEL_DATA: adl_abl = data_i;
      ADL_SEL_S:    adl_abl = reg_s;
      ADL_SEL_ALU:  adl_abl = alu;
      ADL_SEL_VEC:  adl_abl = vector_lo;
      ADL_SEL_VEC1: adl_abl = vector_lo | 8'h01;
      default:      adl_abl = 8'h00;
    endcase
  end

  always_comb begin
    adh_abh = 8'h00;
    case (adh_sel)
      ADH_SEL_PCHS:  adh_abh = pchs;
      ADH_SEL_DATA:  adh_abh = data_i;
      ADH_SEL_ALU:   adh_abh = alu;
      ADH_SEL_ZERO:  adh_abh = 8'h00;
      ADH_SEL_STACK: adh_abh = STACK_PAGE;
      ADH_SEL_VEC:   adh_abh = VECTOR_PAGE;
      default:       adh_abh = 8'h00;
    endcase
  end

  // Must never select pchs: this feeds the PC high mux that produces pchs.
  assign adh_pchs = (adh_sel == ADH_SEL_ALU) ? alu : data_i;

  // Index 0 = ABL, 1 = ABH.
  logic [1:0][7:0] reg_d, reg_q, reg_rst;
  logic [1:0]      reg_en;

  assign reg_d  = {adh_abh, adl_abl};
  assign reg_en = {load_abh, load_abl};
`ifdef RESET_VECTOR_ADDR_EN
  assign reg_rst = {VECTOR_PAGE, RESET_VEC_LO};
`else
  assign reg_rst = {8'h00, 8'h00};
`endif

  for (genvar i = 0; i < 2; i++) begin : g_ab
    ab_reg8 u_reg (
      .clk     (clk),
      .reset   (reset),
      .en      (reg_en[i]),
      .rst_val (reg_rst[i]),
      .d       (reg_d[i]),
      .q       (reg_q[i])
    );
  end

  assign address = {reg_q[1], reg_q[0]};

endmodule

// File: tb/tb_address_bus_select.sv
// Randomized + directed bench for address_bus_select against a lookup-table model.
module tb_address_bus_select;

`ifdef RESET_VECTOR_ADDR_EN
  localparam logic [15:0] RST_ADDR = 16'hFFFC;
`else
  localparam logic [15:0] RST_ADDR = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  adl_sel, adh_sel;
  logic [7:0]  data_i, pcls, pchs, reg_s, alu, vector_lo;
  logic        load_abl, load_abh;
  logic [7:0]  adl_abl, adh_abh, adh_pchs;
  logic [15:0] address;

  int total = 0;
  int bad   = 0;

  // Hand-computed expectations posted by the stimulus for the current cycle.
  logic        lit_adl_v, lit_adh_v, lit_pchs_v, lit_addr_v;
  logic [7:0]  lit_adl, lit_adh, lit_pchs;
  logic [15:0] lit_addr;

  always #5 clk = ~clk;

  address_bus_select dut (
    .clk       (clk),
    .reset     (reset),
    .adl_sel   (adl_sel),
    .adh_sel   (adh_sel),
    .data_i    (data_i),
    .pcls      (pcls),
    .pchs      (pchs),
    .reg_s     (reg_s),
    .alu       (alu),
    .vector_lo (vector_lo),
    .load_abl  (load_abl),
    .load_abh  (load_abh),
    .adl_abl   (adl_abl),
    .adh_abh   (adh_abh),
    .adh_pchs  (adh_pchs),
    .address   (address)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: model from the select tables, checked mid-cycle.
  initial begin : compare
    logic [15:0] maddr;
    logic        mvalid;
    logic [7:0]  adl_tab [8];
    logic [7:0]  adh_tab [8];
    logic [7:0]  eadl, eadh, epchs;
    mvalid = 1'b0;
    maddr  = 16'h0000;
    forever begin
      @(negedge clk);
      adl_tab = '{pcls, data_i, reg_s, alu, vector_lo, vector_lo | 8'h01, 8'h00, 8'h00};
      adh_tab = '{pchs, data_i, alu, 8'h00, 8'h01, 8'hFF, 8'h00, 8'h00};
      eadl  = adl_tab[adl_sel];
      eadh  = adh_tab[adh_sel];
      epchs = (adh_sel == 3'd2) ? alu : data_i;
      chk("model_adl_abl", {8'h00, adl_abl}, {8'h00, eadl});
      chk("model_adh_abh", {8'h00, adh_abh}, {8'h00, eadh});
      chk("model_adh_pchs", {8'h00, adh_pchs}, {8'h00, epchs});
      if (mvalid) chk("model_address", address, maddr);
      if (lit_adl_v)  chk("lit_adl_abl", {8'h00, adl_abl}, {8'h00, lit_adl});
      if (lit_adh_v)  chk("lit_adh_abh", {8'h00, adh_abh}, {8'h00, lit_adh});
      if (lit_pchs_v) chk("lit_adh_pchs", {8'h00, adh_pchs}, {8'h00, lit_pchs});
      if (lit_addr_v) chk("lit_address", address, lit_addr);
      // Advance the model across the coming rising edge.
      if (reset) begin
        maddr  = RST_ADDR;
        mvalid = 1'b1;
      end else if (mvalid) begin
        if (load_abl) maddr[7:0]  = eadl;
        if (load_abh) maddr[15:8] = eadh;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    lit_adl_v = 1'b0; lit_adh_v = 1'b0; lit_pchs_v = 1'b0; lit_addr_v = 1'b0;
  endtask

  initial begin : stim
    logic [7:0] exp_adl [8];
    logic [7:0] exp_adh [8];
    exp_adl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hFC, 8'hFD, 8'h00, 8'h00};
    exp_adh = '{8'hA1, 8'hB2, 8'hC3, 8'h00, 8'h01, 8'hFF, 8'h00, 8'h00};
    lit_adl_v = 1'b0; lit_adh_v = 1'b0; lit_pchs_v = 1'b0; lit_addr_v = 1'b0;
    lit_adl = 8'h00; lit_adh = 8'h00; lit_pchs = 8'h00; lit_addr = 16'h0000;
    reset = 1'b1; adl_sel = 3'd0; adh_sel = 3'd0;
    data_i = 8'h00; pcls = 8'h00; pchs = 8'h00; reg_s = 8'h00; alu = 8'h55;
    vector_lo = 8'h00; load_abl = 1'b1; load_abh = 1'b1;
    adl_sel = 3'd3; adh_sel = 3'd2;

    // Reset beats simultaneous loads.
    cyc();
    cyc();
    lit_addr_v = 1'b1; lit_addr = RST_ADDR;
    cyc();
    reset = 1'b0; load_abl = 1'b0; load_abh = 1'b0;

    // ADL sweep
    pcls = 8'h11; data_i = 8'h22; reg_s = 8'h33; alu = 8'h44; vector_lo = 8'hFC;
    for (int s = 0; s < 8; s++) begin
      adl_sel = s[2:0];
      lit_adl_v = 1'b1; lit_adl = exp_adl[s];
      cyc();
    end

    // ADH sweep
    pchs = 8'hA1; data_i = 8'hB2; alu = 8'hC3;
    for (int s = 0; s < 8; s++) begin
      adh_sel = s[2:0];
      lit_adh_v = 1'b1; lit_adh = exp_adh[s];
      lit_pchs_v = 1'b1; lit_pchs = (s == 2) ? 8'hC3 : 8'hB2;
      cyc();
    end

    // Stack load timing and hold
    adl_sel = 3'd2; reg_s = 8'hFD; adh_sel = 3'd4; load_abl = 1'b1; load_abh = 1'b1;
    cyc();
    load_abl = 1'b0; load_abh = 1'b0; reg_s = 8'h20;
    lit_addr_v = 1'b1; lit_addr = 16'h01FD;
    cyc();
    reg_s = 8'h77;
    lit_addr_v = 1'b1; lit_addr = 16'h01FD;
    cyc();

    // Independent loads
    adl_sel = 3'd3; alu = 8'h34; adh_sel = 3'd1; data_i = 8'h12;
    load_abl = 1'b1; load_abh = 1'b1;
    cyc();
    lit_addr_v = 1'b1; lit_addr = 16'h1234;
    alu = 8'h99; load_abh = 1'b0;
    cyc();
    lit_addr_v = 1'b1; lit_addr = 16'h1299;
    load_abl = 1'b0; load_abh = 1'b1; data_i = 8'h77;
    cyc();
    lit_addr_v = 1'b1; lit_addr = 16'h7799;
    load_abh = 1'b0;
    cyc();

    // Vector fetch
    vector_lo = 8'hFA; adl_sel = 3'd4; adh_sel = 3'd5; load_abl = 1'b1; load_abh = 1'b1;
    cyc();
    lit_addr_v = 1'b1; lit_addr = 16'hFFFA;
    adl_sel = 3'd5;
    cyc();
    lit_addr_v = 1'b1; lit_addr = 16'hFFFB;
    load_abl = 1'b0; load_abh = 1'b0;
    cyc();

    // Mid-stream reset: muxes keep following inputs
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      adl_sel = 3'($urandom_range(0, 7)); adh_sel = 3'($urandom_range(0, 7));
      data_i = 8'($urandom); alu = 8'($urandom); pcls = 8'($urandom); pchs = 8'($urandom);
      load_abl = 1'($urandom); load_abh = 1'($urandom);
      cyc();
    end
    lit_addr_v = 1'b1; lit_addr = RST_ADDR;
    reset = 1'b0;

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      reset     = ($urandom_range(0, 99) < 3);
      adl_sel   = 3'($urandom_range(0, 7));
      adh_sel   = 3'($urandom_range(0, 7));
      data_i    = 8'($urandom);
      pcls      = 8'($urandom);
      pchs      = 8'($urandom);
      reg_s     = 8'($urandom);
      alu       = 8'($urandom);
      vector_lo = 8'($urandom_range(0, 2) * 2 + 8'hFA);
      load_abl  = 1'($urandom);
      load_abh  = 1'($urandom);
      cyc();
    end

    reset = 1'b0; load_abl = 1'b0; load_abh = 1'b0;
    cyc();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
